// File: rtl/core_loader.sv
// Host-side program loader: streams a framed program into a core's instruction RAM,
// launches the core and waits for exit. Optional RUN watchdog via LOADER_WATCHDOG_EN.
module core_loader #(
  parameter int unsigned WATCHDOG_CYCLES = 32'd1000000
) (
  input  logic        sclk,
  input  logic        reset,
  input  logic        host_valid,
  input  logic [31:0] host_data,
  output logic        host_ready,
  output logic        load,
  output logic [31:0] loadAddress,
  output logic [31:0] loadInstruction,
  output logic [31:0] PC1,
  output logic        PC1Load,
  output logic        wake1,
  output logic        RegRuntime1,
  input  logic        CPU1Exit,
  output logic        busy,
  output logic        done,
  output logic        timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_COUNT,
    S_HDR_ENTRY,
    S_LOAD,
    S_LAUNCH,
    S_RUN
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] count_q, count_d;
  logic [31:0] entry_q, entry_d;
  logic        load_q, load_d;
  logic [31:0] load_addr_q, load_addr_d;
  logic [31:0] load_instr_q, load_instr_d;
  logic [31:0] pc_q, pc_d;
  logic        pc_load_q, pc_load_d;
  logic        wake_q, wake_d;
  logic        runtime_q, runtime_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        timeout_q, timeout_d;
  logic        host_ready_q, host_ready_d;
  logic        xfer;

`ifdef LOADER_WATCHDOG_EN
  localparam logic [31:0] WdLast = 32'(WATCHDOG_CYCLES - 1);
  logic [31:0] wd_cnt_q, wd_cnt_d;
`endif

  assign xfer = host_valid & host_ready_q;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    count_d      = count_q;
    entry_d      = entry_q;
    load_d       = 1'b0;
    load_addr_d  = load_addr_q;
    load_instr_d = load_instr_q;
    pc_d         = pc_q;
    pc_load_d    = 1'b0;
    wake_d       = 1'b0;
    runtime_d    = 1'b0;
    done_d       = done_q;
`ifdef LOADER_WATCHDOG_EN
    timeout_d    = timeout_q;
    wd_cnt_d     = wd_cnt_q;
`else
    timeout_d    = 1'b0;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (xfer) begin
          addr_d    = host_data;
          done_d    = 1'b0;
          timeout_d = 1'b0;
          state_d   = S_HDR_COUNT;
        end
      end
      S_HDR_COUNT: begin
        if (xfer) begin
          count_d = host_data;
          state_d = S_HDR_ENTRY;
        end
      end
      S_HDR_ENTRY: begin
        if (xfer) begin
          entry_d = host_data;
          state_d = (count_q != '0) ? S_LOAD : S_LAUNCH;
        end
      end
      S_LOAD: begin
        if (xfer) begin
          load_d       = 1'b1;
          load_addr_d  = addr_q;
          load_instr_d = host_data;
          addr_d       = addr_q + 32'd4;
          count_d      = count_q - 32'd1;
          if (count_q == 32'd1) begin
            state_d = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: begin
        pc_load_d = 1'b1;
        wake_d    = 1'b1;
        pc_d      = entry_q;
        state_d   = S_RUN;
`ifdef LOADER_WATCHDOG_EN
        wd_cnt_d  = '0;
`endif
      end
      S_RUN: begin
        runtime_d = 1'b1;
        // Exit is checked first so it wins over a watchdog expiry in the same cycle.
        if (CPU1Exit) begin
          done_d    = 1'b1;
          runtime_d = 1'b0;
          state_d   = S_IDLE;
        end
`ifdef LOADER_WATCHDOG_EN
        else if (wd_cnt_q >= WdLast) begin
          timeout_d = 1'b1;
          runtime_d = 1'b0;
          state_d   = S_IDLE;
        end else begin
          wd_cnt_d = wd_cnt_q + 32'd1;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase

    host_ready_d = (state_d == S_IDLE) || (state_d == S_HDR_COUNT) ||
                   (state_d == S_HDR_ENTRY) || (state_d == S_LOAD);
    busy_d       = (state_d != S_IDLE);
  end

  always_ff @(posedge sclk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      count_q      <= '0;
      entry_q      <= '0;
      load_q       <= 1'b0;
      load_addr_q  <= '0;
      load_instr_q <= '0;
      pc_q         <= '0;
      pc_load_q    <= 1'b0;
      wake_q       <= 1'b0;
      runtime_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      host_ready_q <= 1'b0;
`ifdef LOADER_WATCHDOG_EN
      wd_cnt_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      count_q      <= count_d;
      entry_q      <= entry_d;
      load_q       <= load_d;
      load_addr_q  <= load_addr_d;
      load_instr_q <= load_instr_d;
      pc_q         <= pc_d;
      pc_load_q    <= pc_load_d;
      wake_q       <= wake_d;
      runtime_q    <= runtime_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
      host_ready_q <= host_ready_d;
`ifdef LOADER_WATCHDOG_EN
      wd_cnt_q     <= wd_cnt_d;
`endif
    end
  end

  assign host_ready      = host_ready_q;
  assign load            = load_q;
  assign loadAddress     = load_addr_q;
  assign loadInstruction = load_instr_q;
  assign PC1             = pc_q;
  assign PC1Load         = pc_load_q;
  assign wake1           = wake_q;
  assign RegRuntime1     = runtime_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign timeout         = timeout_q;

endmodule

// File: doc/core_loader.md
# core_loader

Host-side initiator for a core's program-load and launch interface. Accepts a framed program from a host word stream, writes it into the core's instruction RAM through the `load`/`loadAddress`/`loadInstruction` port, then starts the core with `PC1`/`PC1Load`/`wake1`/`RegRuntime1`. It then waits for `CPU1Exit` and reports completion. One instance sits beside each core in the multi-core top level.

## Interface
- `WATCHDOG_CYCLES`, 1000000: RUN-state cycle limit; only used when the watchdog is compiled in.
- `sclk` in 1: system clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `host_valid` in 1: host word valid.
- `host_data` in 32: host word.
- `host_ready` out 1: loader accepts the word; a transfer occurs when `host_valid & host_ready`.
- `load` out 1: RAM write strobe to the core.
- `loadAddress` out 32: RAM byte address.
- `loadInstruction` out 32: instruction word to write.
- `PC1` out 32: entry PC.
- `PC1Load` out 1: one-cycle PC load strobe.
- `wake1` out 1: one-cycle wake pulse.
- `RegRuntime1` out 1: core runtime enable.
- `CPU1Exit` in 1: core exit flag.
- `busy` out 1: loader is not in IDLE.
- `done` out 1: sticky flag; the last program exited.
- `timeout` out 1: sticky flag; the last program was killed by the watchdog.

## Operation
- Frame format: word0 = base address, word1 = count N (32-bit, unsigned), word2 = entry PC, then N instruction words.
- States: IDLE → HDR_COUNT → HDR_ENTRY → LOAD → LAUNCH → RUN → IDLE.
- IDLE
  - `host_ready`=1.
  - An accepted word latches the base address, clears `done`/`timeout`, and moves to HDR_COUNT.
- HDR_COUNT
  - `host_ready`=1.
  - An accepted word latches N as the remaining count.
  - Moves to HDR_ENTRY.
- HDR_ENTRY
  - `host_ready`=1.
  - An accepted word latches the entry PC.
  - Moves to LOAD if N≠0, else to LAUNCH. N=0 writes no RAM words.
- LOAD
  - `host_ready`=1.
  - Each accepted word produces exactly one `load` cycle carrying the current address and the word.
  - The address then advances by 4, modulo 2^32: 0xFFFFFFFC wraps to 0x00000000.
  - The remaining count decrements by one per word. When the last word is accepted, the state moves to LAUNCH.
  - `host_valid` low stalls the load; no `load` strobe is issued.
- LAUNCH
  - Lasts exactly one cycle; `host_ready`=0.
  - `PC1Load`=1, `wake1`=1, `PC1`=entry PC.
  - Moves to RUN.
- RUN
  - `host_ready`=0, `RegRuntime1`=1; `PC1` holds the entry PC.
  - `CPU1Exit` is sampled only in RUN and is ignored in all other states.
  - `CPU1Exit`=1 sets `done`, drops `RegRuntime1`, and moves to IDLE.
- `busy` = (state ≠ IDLE).
- Host words offered while `host_ready`=0 are not consumed.

## Timing
- All outputs are registered.
- Reset values: every output 0, including `host_ready`. `loadAddress`, `loadInstruction` and `PC1` are 0x00000000; state is IDLE.
- `host_ready` rises on the first clock edge after `reset` deasserts.
- `load` is asserted the cycle after each LOAD handshake and is high for exactly one cycle per word. Back-to-back handshakes give consecutive `load` cycles, one word per cycle.
- `loadAddress` and `loadInstruction` are valid in every cycle in which `load`=1 and hold their values otherwise.
- LAUNCH begins the cycle after the last LOAD handshake, or after the HDR_ENTRY handshake when N=0.
- The `PC1Load`/`wake1` pulse occurs 1 cycle after the final `load` strobe.
- `RegRuntime1` rises 1 cycle after the `PC1Load` pulse.
- Exit latency: `CPU1Exit` sampled high at edge k gives `done`=1, `RegRuntime1`=0 and `host_ready`=1 after edge k.
- Reset mid-operation, in any state: all outputs return to 0 immediately, asynchronously. A partial frame is discarded, and the next frame starts at word0.

## Configuration
- `LOADER_WATCHDOG_EN` defined:
  - A 32-bit counter clears on entry to RUN and increments every RUN cycle.
  - If it reaches `WATCHDOG_CYCLES` before `CPU1Exit`, `timeout` is set, `RegRuntime1` drops, and the state returns to IDLE; `done` stays 0.
  - If `CPU1Exit` and the limit occur in the same cycle, exit wins: `done`=1, `timeout`=0.
- `LOADER_WATCHDOG_EN` not defined:
  - No counter is built; RUN waits indefinitely.
  - `timeout` is tied to 0.

## Test plan
- Basic load:
  - Stimulus: frame {0x100, 3, 0x100, 0xA, 0xB, 0xC} streamed back-to-back, then `CPU1Exit` after 10 cycles.
  - Required: `load` high on 3 consecutive cycles with addresses 0x100/0x104/0x108 carrying 0xA/0xB/0xC.
  - Required: the next cycle has `PC1Load`=`wake1`=1 with `PC1`=0x100; `RegRuntime1` is high until exit; then `done`=1 and `busy`=0.
- Stalled host:
  - Stimulus: same frame with `host_valid` toggling 1-0-1-0.
  - Required: exactly 3 `load` strobes with unchanged addresses/data, and no strobe in any stall cycle.
- Zero count and wrap:
  - Frame {0x0, 0, 0x40}: required response is no `load`, then LAUNCH on the cycle after word2 with `PC1`=0x40.
  - Frame {0xFFFFFFFC, 2, 0, 1, 2}: required addresses are 0xFFFFFFFC then 0x00000000.
- Early exit ignored:
  - Stimulus: `CPU1Exit` held high throughout loading and the LAUNCH cycle.
  - Required: no state change before RUN; `done` sets on the first RUN cycle.
- Reset mid-load:
  - Stimulus: drive `reset` low after 2 of 5 instruction words have loaded.
  - Required: all outputs go to 0 immediately. After release, a new frame {0x200, 1, 0x200, 0x7} loads 0x7 at 0x200.
- Watchdog (`LOADER_WATCHDOG_EN`, `WATCHDOG_CYCLES`=20):
  - Stimulus: never assert `CPU1Exit`.
  - Required: `timeout`=1 and `RegRuntime1`=0 after 20 RUN cycles, with `done`=0.
  - Stimulus: exit on cycle 20.
  - Required: `done`=1 and `timeout`=0.
